// File: rtl/wb_spi_ctrl.sv
// Wishbone-attached SPI master: a small register file with a one-shot bus handshake,
// and one transfer FSM that drives SCLK/MOSI/CS with programmable CPOL, CPHA, length and divider.
module wb_spi_ctrl #(
  parameter int NUM_CS = 3,
  parameter int WORD_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [2:0]        adr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              int_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_o
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t             state;
  logic [2:0]         cs_idx_q;
  logic               cpol_q, cpha_q, ie_q;
  logic [4:0]         len_q;
  logic [DIV_W-1:0]   div_q, cnt;
  logic [31:0]        txdata_q, rxdata_q, rd_data;
  logic               busy_q, done_q, req_seen;
  logic [5:0]         n_q, n_new;
  logic [6:0]         hp, last_hp;
  logic [WORD_W-1:0]  tx_sr, rx_sr, preload;
  logic [NUM_CS-1:0]  cs_new;
  logic               req, accept, reject, wr_ok, ctrl_wr, start, w1c;
  logic               is_ctrl, is_div, is_tx, is_rx, is_stat;
  logic               unused_sel;

  assign unused_sel = ^sel_i;

  assign req     = cyc_i & stb_i;
  assign accept  = req & ~req_seen;
  assign is_ctrl = (adr_i == 3'd0);
  assign is_div  = (adr_i == 3'd1);
  assign is_tx   = (adr_i == 3'd2);
  assign is_rx   = (adr_i == 3'd3);
  assign is_stat = (adr_i == 3'd4);

  // A rejected access must leave every register untouched, so all writes gate on wr_ok.
  assign reject  = (adr_i > 3'd4)
                 | (we_i & is_rx)
                 | (we_i & busy_q & (is_ctrl | is_div | is_tx))
                 | (we_i & is_ctrl & dat_i[31] & (int'(dat_i[2:0]) >= NUM_CS));
  assign wr_ok   = accept & we_i & ~reject;
  assign ctrl_wr = wr_ok & is_ctrl;
  assign start   = ctrl_wr & dat_i[31];
  assign w1c     = wr_ok & is_stat & dat_i[1];

  // Transfer geometry is derived from the CTRL write that launches the frame.
  assign n_new   = (dat_i[9:5] == 5'd0 || int'(dat_i[9:5]) > WORD_W) ? 6'(WORD_W) : {1'b0, dat_i[9:5]};
  assign preload = txdata_q[WORD_W-1:0] << (6'(WORD_W) - n_new);
  assign cs_new  = ~(NUM_CS'(1) << dat_i[2:0]);
  assign last_hp = {n_q, 1'b0} - 7'd1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (adr_i)
      3'd0:    rd_data = {21'b0, ie_q, len_q, cpha_q, cpol_q, cs_idx_q};
      3'd1:    rd_data = 32'(div_q);
      3'd2:    rd_data = txdata_q;
      3'd3:    rd_data = rxdata_q;
      3'd4:    rd_data = {30'b0, done_q, busy_q};
      default: rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      req_seen <= 1'b0;
      cs_idx_q <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      len_q    <= '0;
      ie_q     <= 1'b0;
      div_q    <= '0;
      txdata_q <= '0;
    end else begin
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      req_seen <= req;
      if (accept) begin
        err_o <= reject;
        ack_o <= ~reject;
        if (!we_i && !reject) dat_o <= rd_data;
      end
      if (ctrl_wr) begin
        cs_idx_q <= dat_i[2:0];
        cpol_q   <= dat_i[3];
        cpha_q   <= dat_i[4];
        len_q    <= dat_i[9:5];
        ie_q     <= dat_i[10];
      end
      if (wr_ok && is_div) div_q    <= dat_i[DIV_W-1:0];
      if (wr_ok && is_tx)  txdata_q <= dat_i;
    end
  end

  // Shift edges: half-period hp+1 is leading when hp is odd; MOSI moves on the edge
  // CPHA selects and MISO is sampled on the other one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      hp         <= '0;
      n_q        <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rxdata_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      int_o      <= 1'b0;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_cs_o   <= '1;
    end else begin
      int_o <= done_q & ie_q;
      if (w1c) done_q <= 1'b0;
      case (state)
        SETUP: begin
          if (cnt == div_q) begin
            cnt        <= '0;
            hp         <= '0;
            state      <= SHIFT;
            spi_sclk_o <= ~spi_sclk_o;
            if (cpha_q) begin
              spi_mosi_o <= tx_sr[WORD_W-1];
              tx_sr      <= tx_sr << 1;
            end else begin
              rx_sr <= {rx_sr[WORD_W-2:0], spi_miso_i};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == div_q) begin
            cnt <= '0;
            if (hp == last_hp) begin
              state      <= HOLD;
              spi_mosi_o <= 1'b0;
            end else begin
              hp         <= hp + 7'd1;
              spi_sclk_o <= ~spi_sclk_o;
              if (hp[0] == cpha_q) begin
                spi_mosi_o <= tx_sr[WORD_W-1];
                tx_sr      <= tx_sr << 1;
              end else begin
                rx_sr <= {rx_sr[WORD_W-2:0], spi_miso_i};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == div_q) begin
            cnt      <= '0;
            state    <= DONE;
            spi_cs_o <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0 | 1'b1;
            rxdata_q <= 32'(rx_sr);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Holding DONE set here lets it win over a clear landing in this cycle.
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (ctrl_wr) spi_sclk_o <= dat_i[3];
      if (start) begin
        state      <= SETUP;
        cnt        <= '0;
        busy_q     <= 1'b1;
        n_q        <= n_new;
        rx_sr      <= '0;
        spi_cs_o   <= cs_new;
        spi_mosi_o <= dat_i[4] ? 1'b0 : preload[WORD_W-1];
        tx_sr      <= dat_i[4] ? preload : (preload << 1);
      end
    end
  end

endmodule

// File: tb/tb_wb_spi_ctrl.sv
// Directed bench for wb_spi_ctrl: bus responses are checked by a queue-fed monitor,
// SPI waveform properties by direct checks against hand-computed values.
module tb_wb_spi_ctrl;
  localparam int NUM_CS = 3;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              cyc_i, stb_i, we_i;
  logic [2:0]        adr_i;
  logic [3:0]        sel_i;
  logic [31:0]       dat_i, dat_o;
  logic              ack_o, err_o, int_o;
  logic              spi_sclk_o, spi_mosi_o, miso;
  logic [NUM_CS-1:0] spi_cs_o;
  logic              loop_en, miso_tie;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int                tog;
  time               t_first, t_last;
  logic [NUM_CS-1:0] cs_first;

  always #5 clk = ~clk;
  assign miso = loop_en ? spi_mosi_o : miso_tie;

  wb_spi_ctrl #(.NUM_CS(NUM_CS), .WORD_W(32), .DIV_W(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .int_o(int_o), .spi_sclk_o(spi_sclk_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(miso), .spi_cs_o(spi_cs_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  always @(spi_sclk_o) begin
    if (tog == 0) begin
      t_first  = $time;
      cs_first = spi_cs_o;
    end
    t_last = $time;
    tog++;
  end

  initial forever begin
    @(negedge clk);
    if (ack_o || err_o) begin
      check("ack_err_excl", {31'b0, ack_o & err_o}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'b0, ack_o | err_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_kind"}, {31'b0, err_o}, {31'b0, mon_e.is_err});
        if (mon_e.chk) check({mon_e.name, "_data"}, dat_o, mon_e.data);
      end
    end
  end

  task automatic wb(input bit we, input logic [2:0] adr, input logic [31:0] dat,
                    input bit exp_err, input bit chk, input logic [31:0] exp_dat, input string name);
    exp_t e;
    int   n;
    e.is_err = exp_err; e.chk = chk; e.data = exp_dat; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack_o || err_o) && n < 16);
    if (!(ack_o || err_o)) begin
      check({name, "_timeout"}, {31'b0, ack_o | err_o}, 32'd1);
      exp_q.delete();
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input string name);
    wb(1'b1, adr, dat, 1'b0, 1'b0, 32'd0, name);
  endtask

  task automatic wr_err(input logic [2:0] adr, input logic [31:0] dat, input string name);
    wb(1'b1, adr, dat, 1'b1, 1'b0, 32'd0, name);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string name);
    wb(1'b0, adr, 32'd0, 1'b0, 1'b1, exp, name);
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (spi_cs_o !== '1 && n < 3000);
    check({name, "_frame_end"}, {31'b0, spi_cs_o === '1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    reset_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; sel_i = 4'hF; dat_i = '0; loop_en = 1'b0; miso_tie = 1'b0; tog = 0;
    #12;
    check("rst_cs",   32'(spi_cs_o),   32'h7);
    check("rst_sclk", 32'(spi_sclk_o), 32'h0);
    check("rst_mosi", 32'(spi_mosi_o), 32'h0);
    check("rst_ack",  32'(ack_o),      32'h0);
    check("rst_err",  32'(err_o),      32'h0);
    check("rst_int",  32'(int_o),      32'h0);
    check("rst_dat",  dat_o,           32'h0);
    @(negedge clk); reset_i = 1'b0;
    rd(3'd0, 32'h0, "rst_ctrl");
    rd(3'd1, 32'h0, "rst_div");
    rd(3'd3, 32'h0, "rst_rx");
    rd(3'd4, 32'h0, "rst_status");

    // Mode 0, DIV=0, 8 bits on CS1 with MISO looped back
    loop_en = 1'b1;
    wr(3'd1, 32'd0, "m0_div");
    wr(3'd2, 32'hA5, "m0_tx");
    tog = 0;
    wr(3'd0, 32'h8000_0101, "m0_start");
    wait_frame("m0");
    check("m0_pulses", 32'(tog), 32'd16);
    check("m0_span",   32'(t_last - t_first), 32'd150);
    check("m0_cs",     32'(cs_first), 32'h5);
    check("m0_int",    32'(int_o), 32'h0);
    check("m0_mosi",   32'(spi_mosi_o), 32'h0);
    rd(3'd3, 32'h0000_00A5, "m0_rx");
    rd(3'd4, 32'h2, "m0_status");
    rd(3'd0, 32'h101, "m0_ctrl");

    // Writes while busy are rejected; reads still return the old values
    wr(3'd1, 32'd3, "busy_div");
    wr(3'd2, 32'h3C, "busy_tx");
    wr(3'd0, 32'h8000_0101, "busy_start");
    wr_err(3'd2, 32'h1234, "busy_wr_tx");
    wr_err(3'd0, 32'h0, "busy_wr_ctrl");
    wr_err(3'd1, 32'd7, "busy_wr_div");
    rd(3'd2, 32'h3C, "busy_rd_tx");
    rd(3'd3, 32'hA5, "busy_rd_rx");
    rd(3'd4, 32'h3, "busy_status");
    wait_frame("busy");
    rd(3'd3, 32'h3C, "busy_rx");
    rd(3'd1, 32'd3, "busy_div_kept");
    wr_err(3'd0, 32'h8000_0105, "bad_cs_start");
    rd(3'd4, 32'h2, "bad_cs_status");
    check("bad_cs_idle", 32'(spi_cs_o), 32'h7);
    wr(3'd4, 32'h2, "w1c");
    rd(3'd4, 32'h0, "w1c_status");

    // Mode 3, DIV=3, LEN=0 -> 32 bits, MISO tied high
    loop_en = 1'b0; miso_tie = 1'b1;
    wr(3'd2, 32'h8000_0001, "m3_tx");
    wr(3'd0, 32'h18, "m3_cfg");
    check("m3_idle_hi", 32'(spi_sclk_o), 32'h1);
    tog = 0;
    wr(3'd0, 32'h8000_0018, "m3_start");
    wait_frame("m3");
    check("m3_pulses", 32'(tog), 32'd64);
    check("m3_span",   32'(t_last - t_first), 32'd2520);
    check("m3_cs",     32'(cs_first), 32'h6);
    check("m3_sclk_idle", 32'(spi_sclk_o), 32'h1);
    rd(3'd3, 32'hFFFF_FFFF, "m3_rx");

    // Interrupt, W1C and a W1C colliding with the DONE cycle
    wr(3'd4, 32'h2, "irq_clr0");
    rd(3'd4, 32'h0, "irq_status0");
    wr(3'd1, 32'd0, "irq_div");
    wr(3'd2, 32'h5A, "irq_tx");
    loop_en = 1'b1;
    wr(3'd0, 32'h8000_0502, "irq_start");
    wait_frame("irq");
    wr(3'd4, 32'h2, "irq_w1c_done");
    rd(3'd4, 32'h2, "irq_done_wins");
    check("irq_int_set", 32'(int_o), 32'h1);
    rd(3'd3, 32'h5A, "irq_rx");
    wr(3'd4, 32'h2, "irq_w1c");
    check("irq_int_clr", 32'(int_o), 32'h0);
    rd(3'd4, 32'h0, "irq_status1");

    // Bad addresses and a strobe held for four cycles
    wb(1'b0, 3'd6, 32'd0, 1'b1, 1'b0, 32'd0, "rd_adr6");
    wr_err(3'd5, 32'h1, "wr_adr5");
    wr_err(3'd7, 32'h1, "wr_adr7");
    wr_err(3'd3, 32'h1, "wr_rx");
    exp_q.push_back('{is_err: 1'b0, chk: 1'b1, data: 32'h0, name: "held"});
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd4;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_o) acks++;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack_o) acks++;
    end
    check("held_acks", 32'(acks), 32'd1);

    // Reset in the middle of SHIFT
    wr(3'd1, 32'd3, "abort_div");
    tog = 0;
    wr(3'd0, 32'h8000_0208, "abort_start");
    repeat (20) @(posedge clk);
    #3;
    check("abort_in_shift", {31'b0, tog > 0}, 32'd1);
    reset_i = 1'b1;
    #1;
    check("abort_cs",   32'(spi_cs_o),   32'h7);
    check("abort_sclk", 32'(spi_sclk_o), 32'h0);
    check("abort_mosi", 32'(spi_mosi_o), 32'h0);
    @(negedge clk); reset_i = 1'b0;
    rd(3'd4, 32'h0, "abort_status");
    rd(3'd3, 32'h0, "abort_rx");
    rd(3'd0, 32'h0, "abort_ctrl");
    rd(3'd2, 32'h0, "abort_tx");

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_spi_ctrl.md
WB_SPI_CTRL -- requirements
Module: wb_spi_ctrl

Interface
REQ-001 SHALL have parameter NUM_CS, default 3, meaning the number of independent active-low chip selects (legal range 1..8).
REQ-002 SHALL have parameter WORD_W, default 32, meaning the maximum transfer length in bits (legal range 8..32).
REQ-003 SHALL have parameter DIV_W, default 8, meaning the width of the SCLK divider field.
REQ-004 SHALL use one clock and an asynchronous active-high reset, with ports named clk_i and reset_i.
REQ-005 SHALL have these ports (name, direction, width, meaning):
 - clk_i  in  1  system/Wishbone clock
 - reset_i  in  1  async active-high reset
 - cyc_i  in  1  Wishbone cycle
 - stb_i  in  1  Wishbone strobe
 - we_i  in  1  write enable
 - adr_i  in  3  word address
 - sel_i  in  4  byte selects; ignored, all accesses are 32-bit
 - dat_i  in  32  write data
 - dat_o  out  32  read data
 - ack_o  out  1  access accepted
 - err_o  out  1  access rejected
 - int_o  out  1  transfer-done interrupt
 - spi_sclk_o  out  1  SPI clock
 - spi_mosi_o  out  1  master out
 - spi_miso_i  in  1  master in
 - spi_cs_o  out  NUM_CS  chip selects, active low

Function
REQ-006 SHALL use this register map:
 - adr 0 CTRL: [2:0] CS index, [3] CPOL, [4] CPHA, [9:5] LEN, [10] IE, [31] START (write-only, reads 0)
 - adr 1 DIV: [DIV_W-1:0]
 - adr 2 TXDATA
 - adr 3 RXDATA: read-only
 - adr 4 STATUS: [0] BUSY (RO), [1] DONE (W1C)
REQ-007 SHALL assert ack_o or err_o for exactly one cycle, in the cycle after cyc_i&stb_i is sampled high, and never both; a held strobe SHALL NOT be re-acknowledged until it deasserts.
REQ-008 SHALL assert err_o, with no state change, for: adr 5..7; a write to RXDATA; a write to CTRL, DIV or TXDATA while BUSY; START with a CS index >= NUM_CS.
REQ-009 SHALL start a transfer on an accepted CTRL write with START=1, setting BUSY in the following cycle.
REQ-010 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD and DONE.
 - IDLE -> SETUP on START.
 - SETUP: selected CS low for one half-period.
 - SHIFT: 2*N half-periods.
 - HOLD: CS still low for one half-period.
 - DONE: one cycle; CS high, BUSY cleared, DONE set; then IDLE.
REQ-011 SHALL set half-period = DIV+1 clk_i cycles; DIV=0 gives SCLK = clk_i/2.
REQ-012 SHALL set bit count N = LEN when 1 <= LEN <= WORD_W, and N = WORD_W when LEN = 0 or LEN > WORD_W.
REQ-013 SHALL transmit TXDATA[N-1:0] MSB first, and SHALL load RXDATA right-justified with bits above N cleared.
REQ-014 SHALL hold spi_sclk_o at CPOL outside SHIFT.
REQ-015 SHALL, for CPHA=0, present the MOSI bit at SETUP entry and sample MISO on leading edges; for CPHA=1, shift MOSI on leading edges and sample on trailing edges.
REQ-016 SHALL update RXDATA only in DONE; reads during BUSY return the previous value.
REQ-017 SHALL drive int_o = DONE & IE, registered; writing STATUS[1]=1 clears DONE, and a DONE set in the same cycle wins.
REQ-018 SHALL keep all unselected CS lines high at all times, and SHALL drive spi_mosi_o low outside SETUP and SHIFT.

Reset
REQ-019 SHALL on reset_i drive, immediately and asynchronously:
 - spi_cs_o all ones, spi_sclk_o 0, spi_mosi_o 0, ack_o 0, err_o 0, int_o 0, dat_o 0
 - all registers 0 and FSM to IDLE
REQ-020 SHALL, on reset mid-transfer, abort the transfer with no DONE set and RXDATA = 0.

Verification
REQ-021 SHALL pass: DIV=0, LEN=8, CPOL=0, CPHA=0, CS=1, TX=0xA5, MISO looped to MOSI -> 8 SCLK pulses at clk/2, spi_cs_o=3'b101 during the frame, RXDATA=0x000000A5, DONE=1.
REQ-022 SHALL pass: LEN=0, DIV=3, CPOL=1, CPHA=1, TX=0x80000001, MISO tied 1 -> 32 pulses with half-period 4 cycles, idle SCLK high, RXDATA=0xFFFFFFFF.
REQ-023 SHALL pass: write TXDATA while BUSY -> err_o pulse, TXDATA unchanged; START with CS=5 at NUM_CS=3 -> err_o, BUSY stays 0.
REQ-024 SHALL pass: IE=1, transfer completes -> int_o=1; write STATUS=0x2 -> int_o=0 one cycle later; a W1C in the DONE cycle -> DONE stays 1.
REQ-025 SHALL pass: reset_i asserted in mid-SHIFT -> spi_cs_o all ones and SCLK 0 in the same cycle, BUSY=0, RXDATA=0.
REQ-026 SHALL pass: read adr 6 -> err_o; stb_i held for 4 cycles -> exactly one ack_o.
